// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the round-robin SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2
  } arb_state_e;

  localparam int unsigned BEAT_W = 8;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker: first requester after last_i, wrapping.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the farthest candidate back to last_i+1 so the nearest one wins.
  always_comb begin
    logic [IW:0] sum;
    sum     = '0;
    idx_o   = last_i;
    valid_o = 1'b0;
    for (int k = int'(N); k > 0; k--) begin
      sum = {1'b0, last_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      if (req_i[sum[IW-1:0]]) begin
        idx_o   = sum[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// N-client SDRAM master-port arbiter: exclusive loader during init, then
// round-robin with bounded bursts and a per-frame priority token.
module sdram_arbiter_rr
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned PRIO_CLIENT = 1,
  localparam int unsigned IW         = idx_w(NUM_CLIENTS),
  localparam int unsigned BE_W       = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          init_done,
  input  logic                          new_frame,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cl_be,
  input  logic [NUM_CLIENTS-1:0]        cl_read,
  input  logic [NUM_CLIENTS-1:0]        cl_write,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
  output logic [NUM_CLIENTS-1:0]        cl_ac,
  output logic [DATA_W-1:0]             cl_rddata,
  output logic [ADDR_W-1:0]             ar_addr,
  output logic [BE_W-1:0]               ar_be,
  output logic                          ar_read,
  output logic                          ar_write,
  output logic [DATA_W-1:0]             ar_wrdata,
  input  logic                          ar_ac,
  input  logic [DATA_W-1:0]             ar_rddata,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy
);

  localparam logic [IW-1:0]     PRIO_IDX = IW'(PRIO_CLIENT);
  localparam logic [IW-1:0]     LAST_RST = IW'(NUM_CLIENTS - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              tok_q, tok_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          owner;

  logic [ADDR_W-1:0] addr_a   [NUM_CLIENTS];
  logic [BE_W-1:0]   be_a     [NUM_CLIENTS];
  logic [DATA_W-1:0] wrdata_a [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_a[g]   = cl_addr[g*ADDR_W +: ADDR_W];
    assign be_a[g]     = cl_be[g*BE_W +: BE_W];
    assign wrdata_a[g] = cl_wrdata[g*DATA_W +: DATA_W];
  end

  assign req       = cl_read | cl_write;
  assign cl_rddata = ar_rddata;
  assign grant_idx = reset_n ? grant_q : '0;

  rr_pick #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // A pending frame token pre-empts the rotation for the real-time client only.
  assign winner = (tok_q && req[PRIO_IDX]) ? PRIO_IDX : pick_idx;
  assign owner  = (state_q == S_BUSY) ? grant_q : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      grant_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
      tok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      tok_q   <= tok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    tok_d     = tok_q;
    ar_addr   = addr_a[owner];
    ar_be     = be_a[owner];
    ar_wrdata = wrdata_a[owner];
    ar_read   = 1'b0;
    ar_write  = 1'b0;
    cl_ac     = '0;
    busy      = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_done) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_BUSY;
          grant_d = winner;
          beat_d  = '0;
          if (winner == PRIO_IDX) begin
            tok_d = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (!req[grant_q]) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end else if (ar_ac) begin
          if (beat_q == BEAT_MAX) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = S_INIT;
    endcase

    // Frame strobe outranks the same-cycle token clear.
    if (new_frame && (state_q != S_INIT)) begin
      tok_d = 1'b1;
    end

    if ((state_q == S_INIT) || (state_q == S_BUSY)) begin
      busy         = 1'b1;
      ar_write     = cl_write[owner];
      ar_read      = cl_read[owner] & ~cl_write[owner];
      cl_ac[owner] = ar_ac;
    end

    if (!reset_n) begin
      ar_read  = 1'b0;
      ar_write = 1'b0;
      cl_ac    = '0;
      busy     = 1'b0;
    end
  end

endmodule

// File: doc/sdram_arbiter_rr.md
Name: sdram_arbiter_rr

Overview:
- Parametrised N-client arbiter in front of the single-port SDRAM controller master interface.
- Successor to the fixed init/PCM arbiter.
- During the init phase, client 0 (the SD-card-to-SDRAM loader) has exclusive ownership.
- After init, requesting clients are served round-robin, with bounded bursts.
- A per-frame priority token guarantees the designated real-time client (audio PCM) is served first after each new_frame.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8); client 0 is the init loader.
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 16, data width; byte-enable width is DATA_W/8.
- MAX_BURST, 8, max consecutive acknowledged transfers per grant before forced rotation (1..255).
- PRIO_CLIENT, 1, client index that receives the per-frame priority token.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- init_done  in  1  level; loader finished, leave init phase
- new_frame  in  1  single-cycle frame strobe
- cl_addr  in  NUM_CLIENTS*ADDR_W  packed client addresses, client i at slice i
- cl_be  in  NUM_CLIENTS*(DATA_W/8)  packed byte enables
- cl_read  in  NUM_CLIENTS  read requests
- cl_write  in  NUM_CLIENTS  write requests
- cl_wrdata  in  NUM_CLIENTS*DATA_W  packed write data
- cl_ac  out  NUM_CLIENTS  per-client acknowledge; transfer complete
- cl_rddata  out  DATA_W  read data broadcast to all clients; valid with cl_ac
- ar_addr  out  ADDR_W  to SDRAM controller
- ar_be  out  DATA_W/8
- ar_read  out  1
- ar_write  out  1
- ar_wrdata  out  DATA_W
- ar_ac  in  1  controller acknowledge, one-cycle pulse per completed transfer; ar_rddata valid same cycle on reads
- ar_rddata  in  DATA_W
- grant_idx  out  $clog2(NUM_CLIENTS)  current owner (debug/status)
- busy  out  1  a client currently holds the port

Behaviour:
- Client protocol: request = cl_read[i] | cl_write[i]. Address, be, data and request are held stable until cl_ac[i]. Read and write are never both set. A write with cl_read and cl_write both set is treated as a write, and the read is ignored.
- States: S_INIT, S_IDLE, S_BUSY. Registers: grant (index), last (index), beat (8-bit), frame_tok.
- Reset (reset_n low at clk edge):
  - State becomes S_INIT; grant=0, last=NUM_CLIENTS-1, beat=0, frame_tok=0.
  - ar_read, ar_write, cl_ac, busy are forced 0 while reset_n is low. grant_idx=0.
  - Reset mid-transfer simply abandons the transfer; the controller must tolerate request drop.
- S_INIT:
  - Port muxed from client 0; cl_ac[0]=ar_ac; other cl_ac=0; busy=1.
  - Requests from other clients are ignored (not acked).
  - init_done=1 -> S_IDLE next cycle. A transfer acked in the same cycle still completes normally.
- S_IDLE:
  - ar_read=ar_write=0; busy=0.
  - If any request: choose the winner, latch grant, beat=0, go to S_BUSY. Requests wait one cycle of arbitration latency.
  - Winner selection: if frame_tok and PRIO_CLIENT requests, choose PRIO_CLIENT. Otherwise choose the first requesting index scanning last+1, last+2, ... with wrap modulo NUM_CLIENTS.
  - No request: stay in S_IDLE.
- S_BUSY:
  - ar_* are muxed combinationally from client grant; cl_ac[grant]=ar_ac; all other cl_ac=0.
  - If request[grant]=0: go to S_IDLE, last=grant. Zero ack is allowed; the client withdrew.
  - If ar_ac=1 and beat==MAX_BURST-1: go to S_IDLE, last=grant (forced rotation).
  - If ar_ac=1 otherwise: beat++ and stay. The client may present its next request immediately.
- frame_tok:
  - Set on new_frame.
  - Cleared on the cycle PRIO_CLIENT is latched as grant in S_IDLE.
  - new_frame in that same cycle: set wins (token stays 1).
  - new_frame during S_INIT is ignored.
- cl_rddata = ar_rddata always (broadcast); clients qualify it with their cl_ac.
- Boundaries:
  - Single requester re-wins after every rotation, which costs 1 idle cycle.
  - last wrap from NUM_CLIENTS-1 goes to 0.
  - beat never exceeds MAX_BURST-1.

Decomposition:
- Package sdram_arb_pkg: state enum (S_INIT, S_IDLE, S_BUSY) and a clog2-based index width helper constant.
- Sub-module rr_pick: combinational priority rotator, inputs req vector and last index, outputs next index and valid. Instantiated once.

Test Plan:
- Init: client 0 issues 3 writes (addr 0x0,0x1,0x2) while client 2 requests -> only cl_ac[0] pulses 3 times; after init_done, client 2 is acked ≥2 cycles later.
- Round-robin: clients 1,2,3 request continuously, MAX_BURST=2, no frame -> grant order 1,2,3,1,... with exactly 2 acks per grant and 1 idle cycle between grants.
- Priority token: clients 2,3 busy, pulse new_frame while client 2 is owner; client 1 requests -> after client 2's burst ends, grant=1 before 3; frame_tok=0 afterwards.
- Read path: client 3 reads addr 0x1ABCD, controller returns 0xBEEF with ar_ac -> cl_ac[3]=1 and cl_rddata=0xBEEF in that cycle, no other cl_ac asserted.
- Withdraw/reset: client 1 drops request before ack -> S_IDLE next cycle, no ack; reset_n low mid-burst -> ar_read/ar_write=0 during reset, state S_INIT after.
